fp_mul_normalizer: RTL and testbench
====================================

FP_MUL_NORMALIZER -- requirements
Module: fp_mul_normalizer

Interface
REQ-001 SHALL have parameter N, default 25, meaning the signed significand width fed to the Booth multiplier; the product width is 2N.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning product, a and b are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept an operand set.
REQ-006 SHALL have port product, input, 2N, the Booth result of {0,1,a_frac} x {0,1,b_frac}.
REQ-007 SHALL have ports a and b, input, 32 each, the original IEEE-754 single operands.
REQ-008 SHALL have port result, output, 32, the packed IEEE-754 single product.
REQ-009 SHALL have port out_valid, output, 1, meaning result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-011 SHALL have ports overflow, underflow and invalid, output, 1 each, the exception flags for the current result.

Function
REQ-012 SHALL be an FSM with states IDLE, NORM, ROUND, PACK and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1 at a clock edge; product, a and b SHALL be registered on that edge and the FSM SHALL move to NORM.
REQ-014 NORM SHALL use only product[47:0], treating bit 46 as the weight-1 position.
- If product[47]=1: shift right 1 and set norm_inc=1.
- Otherwise: norm_inc=0.
REQ-015 NORM SHALL keep the 24-bit significand, guard bit = next lower bit, sticky = OR of all remaining lower bits.
REQ-016 NORM SHALL compute the exponent in 10-bit signed arithmetic: e = a[30:23] + b[30:23] - 127 + norm_inc.
REQ-017 ROUND SHALL apply round-to-nearest-even.
- Increment when guard & (sticky | lsb).
- If the increment carries out of 24 bits: significand becomes 1.0 and e increments by 1.
REQ-018 PACK SHALL form sign = a[31]^b[31] and apply special cases in this priority:
- Either operand NaN: result 0x7FC00000, invalid=1.
- inf x zero: result 0x7FC00000, invalid=1.
- Either operand inf: result {sign,0xFF,0}.
- Either operand zero (exp=0, denormals treated as zero): result {sign,31'b0}.
- e >= 255: result {sign,0xFF,0}, overflow=1.
- e <= 0: result {sign,31'b0}, underflow=1.
- Otherwise: result {sign, e[7:0], significand[22:0]}.
REQ-019 From PACK the FSM SHALL go to DONE; out_valid SHALL be 1 only in DONE, exactly 4 clock edges after the accepting edge.
REQ-020 In DONE, result and flags SHALL hold stable while out_ready=0; on out_valid & out_ready the FSM SHALL return to IDLE.
REQ-021 The block SHALL NOT accept new input while not in IDLE; in_valid outside IDLE SHALL be ignored and cause no state change.
REQ-022 Flags SHALL be mutually consistent: at most one of overflow, underflow and invalid is 1 per result, and all three are 0 when out_valid=0.

Reset
REQ-023 On rst_n=0, regardless of the clock, the block SHALL enter IDLE with in_ready=1 (after reset), out_valid=0, result=0 and all flags 0.
REQ-024 Reset asserted mid-operation (NORM through DONE) SHALL discard the operation; no out_valid pulse SHALL follow reset release until a new transfer.

Verification
REQ-025 1.0x1.0: a=b=0x3F800000, product=2^46 -> result 0x3F800000, all flags 0, out_valid 4 edges after acceptance.
REQ-026 1.5x1.5: a=b=0x3FC00000, product=0x900000000000 -> result 0x40100000 (normalize path, norm_inc=1).
REQ-027 Rounding: a=b=0x3F800001, product=2^46+2^24+1 -> result 0x3F800002 (guard=0, sticky=1, no increment).
REQ-028 Exceptions:
- a=0x7F000000, b=0x40000000, product=2^46 -> result 0x7F800000, overflow=1.
- a=0x7F800000, b=0x00000000 -> result 0x7FC00000, invalid=1.
REQ-029 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, extra in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-030 Reset in ROUND: pulse rst_n=0 -> out_valid=0, in_ready=1 immediately; no stale result appears afterward.

Source files
------------

// File: rtl/fp_mul_normalizer.sv
// Post-multiply stage of a single-precision FP multiplier: takes the Booth significand
// product plus the original operands and normalizes, rounds (RNE) and packs the result.
module fp_mul_normalizer #(
    parameter int N = 25
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] product,
    input  logic [31:0]    a,
    input  logic [31:0]    b,
    output logic [31:0]    result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           overflow,
    output logic           underflow,
    output logic           invalid
);

    typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] a_q, b_q;
    logic [47:0] prod_q;
    logic [23:0] sig_q;
    logic        guard_q, sticky_q;
    logic [9:0]  exp_q;
    logic [31:0] result_q;
    logic        ovf_q, unf_q, inv_q;
    logic        out_valid_q;

    // Only the low 48 bits carry the 24x24 significand product.
    logic unused_product_hi;
    assign unused_product_hi = ^product[2*N-1:47];

    logic [23:0] norm_sig;
    logic        norm_guard, norm_sticky, norm_inc;
    logic [9:0]  norm_exp;
    logic [24:0] round_sum;
    logic [23:0] round_sig;
    logic [9:0]  round_exp;
    logic        round_up;
    logic [31:0] pack_result;
    logic        pack_ovf, pack_unf, pack_inv;
    logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = PACK;
            PACK:    state_next = DONE;
            DONE:    if (out_valid_q && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        norm_inc = prod_q[47];
        if (norm_inc) begin
            norm_sig    = prod_q[47:24];
            norm_guard  = prod_q[23];
            norm_sticky = |prod_q[22:0];
        end else begin
            norm_sig    = prod_q[46:23];
            norm_guard  = prod_q[22];
            norm_sticky = |prod_q[21:0];
        end
        norm_exp = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'd127 + {9'd0, norm_inc};
    end

    // A carry out of the significand means it rounded up to exactly 2.0.
    always_comb begin
        round_up  = guard_q & (sticky_q | sig_q[0]);
        round_sum = {1'b0, sig_q} + {24'd0, round_up};
        round_sig = round_sum[23:0];
        round_exp = exp_q;
        if (round_sum[24]) begin
            round_sig = 24'h800000;
            round_exp = exp_q + 10'd1;
        end
    end

    always_comb begin
        sign        = a_q[31] ^ b_q[31];
        a_nan       = (&a_q[30:23]) & (|a_q[22:0]);
        b_nan       = (&b_q[30:23]) & (|b_q[22:0]);
        a_inf       = (&a_q[30:23]) & ~(|a_q[22:0]);
        b_inf       = (&b_q[30:23]) & ~(|b_q[22:0]);
        a_zero      = (a_q[30:23] == 8'd0);
        b_zero      = (b_q[30:23] == 8'd0);
        pack_result = {sign, exp_q[7:0], sig_q[22:0]};
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        pack_inv    = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            pack_result = 32'h7FC00000;
            pack_inv    = 1'b1;
        end else if (a_inf || b_inf) begin
            pack_result = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            pack_result = {sign, 31'd0};
        end else if (!exp_q[9] && (exp_q >= 10'd255)) begin
            pack_result = {sign, 8'hFF, 23'd0};
            pack_ovf    = 1'b1;
        end else if (exp_q[9] || (exp_q == 10'd0)) begin
            pack_result = {sign, 31'd0};
            pack_unf    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            sig_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= a;
                    b_q    <= b;
                    prod_q <= product[47:0];
                end
                NORM: begin
                    sig_q    <= norm_sig;
                    guard_q  <= norm_guard;
                    sticky_q <= norm_sticky;
                    exp_q    <= norm_exp;
                end
                ROUND: begin
                    sig_q <= round_sig;
                    exp_q <= round_exp;
                end
                PACK: begin
                    result_q <= pack_result;
                    ovf_q    <= pack_ovf;
                    unf_q    <= pack_unf;
                    inv_q    <= pack_inv;
                end
                default: ;
            endcase
        end
    end

    // out_valid rises one edge after entering DONE, so the result is presented
    // on the fourth edge after acceptance from a fully settled register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    out_valid_q <= 1'b0;
        else if (state != DONE)        out_valid_q <= 1'b0;
        else if (!out_valid_q)         out_valid_q <= 1'b1;
        else if (out_ready)            out_valid_q <= 1'b0;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = out_valid_q & ovf_q;
    assign underflow = out_valid_q & unf_q;
    assign invalid   = out_valid_q & inv_q;

endmodule

// File: tb/tb_fp_mul_normalizer.sv
// Directed-vector bench for fp_mul_normalizer: latency, rounding, exceptions,
// backpressure and mid-operation reset.
module tb_fp_mul_normalizer;

    localparam int N = 25;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] product;
    logic [31:0]    a, b;
    logic [31:0]    result;
    logic           out_valid;
    logic           out_ready;
    logic           overflow, underflow, invalid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string          name;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [2*N-1:0] product;
        logic [31:0]    exp_result;
        logic           exp_ovf;
        logic           exp_unf;
        logic           exp_inv;
    } vec_t;

    vec_t vecs[$];

    fp_mul_normalizer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic check_output(input vec_t v);
        check({v.name, " result"}, result, v.exp_result);
        check({v.name, " flags"}, {29'd0, overflow, underflow, invalid},
              {29'd0, v.exp_ovf, v.exp_unf, v.exp_inv});
    endtask

    // Transfers one operand set, then measures edges until out_valid.
    task automatic apply_stimulus(input vec_t v, output int latency);
        @(negedge clk);
        check({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        product  = v.product;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        latency  = 0;
        while (!out_valid && latency < 20) begin
            @(posedge clk);
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic add_vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                           input logic [2*N-1:0] p, input logic [31:0] r,
                           input logic o, input logic u, input logic i);
        vec_t v;
        v.name = name; v.a = va; v.b = vb; v.product = p;
        v.exp_result = r; v.exp_ovf = o; v.exp_unf = u; v.exp_inv = i;
        vecs.push_back(v);
    endtask

    initial begin
        int   lat;
        vec_t v;
        logic [31:0] held;

        add_vec("one_x_one",    32'h3F800000, 32'h3F800000, 50'h4000_0000_0000, 32'h3F800000, 0, 0, 0);
        add_vec("1p5_x_1p5",    32'h3FC00000, 32'h3FC00000, 50'h9000_0000_0000, 32'h40100000, 0, 0, 0);
        add_vec("sticky_noinc", 32'h3F800001, 32'h3F800001, 50'h4000_0100_0001, 32'h3F800002, 0, 0, 0);
        add_vec("tie_odd_up",   32'h3F800000, 32'h3F800000, 50'h4000_00C0_0000, 32'h3F800002, 0, 0, 0);
        add_vec("tie_even",     32'h3F800000, 32'h3F800000, 50'h4000_0040_0000, 32'h3F800000, 0, 0, 0);
        add_vec("round_carry",  32'h3F800000, 32'h3F800000, 50'h7FFF_FFC0_0000, 32'h40000000, 0, 0, 0);
        add_vec("norm_round",   32'h3F800000, 32'h3F800000, 50'h8000_0080_0001, 32'h40000001, 0, 0, 0);
        add_vec("overflow",     32'h7F000000, 32'h40000000, 50'h4000_0000_0000, 32'h7F800000, 1, 0, 0);
        add_vec("exp_254",      32'h7F000000, 32'h3F800000, 50'h4000_0000_0000, 32'h7F000000, 0, 0, 0);
        add_vec("exp_255_norm", 32'h7F000000, 32'h3F800000, 50'h8000_0000_0000, 32'h7F800000, 1, 0, 0);
        add_vec("exp_1",        32'h00800000, 32'h3F800000, 50'h4000_0000_0000, 32'h00800000, 0, 0, 0);
        add_vec("exp_0_neg",    32'h80800000, 32'h3F000000, 50'h4000_0000_0000, 32'h80000000, 0, 1, 0);
        add_vec("underflow",    32'h00800000, 32'h00800000, 50'h4000_0000_0000, 32'h00000000, 0, 1, 0);
        add_vec("inf_x_zero",   32'h7F800000, 32'h00000000, 50'h0,              32'h7FC00000, 0, 0, 1);
        add_vec("nan_x_one",    32'h7FC00000, 32'h3F800000, 50'h4000_0000_0000, 32'h7FC00000, 0, 0, 1);
        add_vec("nan_x_zero",   32'h7FC00001, 32'h00000000, 50'h0,              32'h7FC00000, 0, 0, 1);
        add_vec("inf_x_neg2",   32'h7F800000, 32'hC0000000, 50'h4000_0000_0000, 32'hFF800000, 0, 0, 0);
        add_vec("neg_zero",     32'h80000000, 32'h3F800000, 50'h0,              32'h80000000, 0, 0, 0);
        add_vec("denorm_zero",  32'h00000001, 32'h3F800000, 50'h0,              32'h00000000, 0, 0, 0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        product   = '0;
        #1;
        check("reset in_ready",  {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result",    result, 32'd0);
        check("reset flags",     {29'd0, overflow, underflow, invalid}, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            apply_stimulus(v, lat);
            check({v.name, " latency"}, lat, 32'd4);
            check_output(v);
            @(negedge clk);
            check({v.name, " back_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Backpressure: result holds, extra in_valid is ignored.
        out_ready = 1'b0;
        apply_stimulus(vecs[1], lat);
        check("bp latency", lat, 32'd4);
        held = result;
        check("bp result", held, 32'h40100000);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            a        = 32'h7F800000;
            b        = 32'h00000000;
            product  = '0;
            @(posedge clk);
            @(negedge clk);
            check("bp hold result", result, 32'h40100000);
            check("bp hold valid",  {30'd0, out_valid, in_ready}, 32'd2);
            check("bp hold flags",  {29'd0, overflow, underflow, invalid}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp release", {30'd0, out_valid, in_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp no ghost", {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Reset while in ROUND discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        product  = 50'h4000_0000_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_round in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst_round out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_round result",    result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_round no stale", {31'd0, out_valid}, 32'd0);
        end

        apply_stimulus(vecs[7], lat);
        check("post_reset latency", lat, 32'd4);
        check_output(vecs[7]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
